mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the core's instruction and data memory ports: it serves INST read, DATA read and DATA write requests.
- Backing store is a single-port synchronous RAM, so at most one RAM access happens per cycle.
- Colliding requests are serialised with MEM_WAIT.
- Sits between the core and on-chip RAM, in the MMU position.

Parameters:
ADDR_W, 14, RAM word-address width (RAM depth = 2^ADDR_W 32-bit words).

Ports:
CLK  input  1  clock; all state on rising edge
RST  input  1  asynchronous, active-low reset
INST_RDEN  input  1  instruction read request
INST_RIADDR  input  32  instruction byte address
INST_ROADDR  output  32  byte address of the returned instruction
INST_RVALID  output  1  instruction response valid
INST_RDATA  output  32  instruction word
DATA_RDEN  input  1  data read request
DATA_RIADDR  input  32  data read byte address
DATA_ROADDR  output  32  byte address of the returned data
DATA_RVALID  output  1  data response valid
DATA_RDATA  output  32  data word
DATA_WREN  input  1  data write request (full word)
DATA_WADDR  input  32  data write byte address
DATA_WDATA  input  32  write data
MEM_WAIT  output  1  stall to core; the core holds all request inputs stable while high
RAM_EN  output  1  RAM access enable
RAM_WE  output  1  RAM write enable
RAM_ADDR  output  ADDR_W  RAM word address = byte address [ADDR_W+1:2]; upper bits ignored
RAM_WDATA  output  32  RAM write data
RAM_RDATA  input  32  RAM read data, valid the cycle after a read access

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, pending mask=0, issue tag cleared.
  - All RVALID/ROADDR/RDATA = 0.
  - While RST=0, MEM_WAIT, RAM_EN and RAM_WE are forced to 0.
- Priority: DATA_WREN > DATA_RDEN > INST_RDEN.
- RAM drive is combinational, from the current requests (IDLE) or the pending mask (SERIAL).
- FSM:
  - IDLE, 0 or 1 request: issue it this cycle, MEM_WAIT=0, stay in IDLE.
  - IDLE, ≥2 requests: issue the highest-priority one, MEM_WAIT=1, latch the remaining requests into the pending mask, go to SERIAL.
  - SERIAL: issue the highest-priority pending request using the held core inputs, and clear its bit.
    - MEM_WAIT=1 if other bits remain.
    - MEM_WAIT=0 if it is the last; return to IDLE.
- Worst-case sequence (three requests): MEM_WAIT pattern 1,1,0 with RAM order W, DR, IR.
- Issue tag: for each read, a register records {valid, port, byte address}.
  - Next cycle: RAM_RDATA and the address are captured into that port's response register, and RVALID is set.
- Read latency: request in cycle N → RVALID/ROADDR/RDATA visible in cycle N+2.
  - Back-to-back reads are fully pipelined (one per cycle when there are no collisions).
- Response hold:
  - RVALID clears at the edge ending a cycle in which it was high and MEM_WAIT=0 (consumed), unless a new capture for that port occurs at the same edge (the new capture wins).
  - While MEM_WAIT=1, the response is held unchanged.
- Writes produce no response. RAM_WE=1 and RAM_WDATA=DATA_WDATA only in the write's issue cycle.
- Read-after-write to the same address in a collision is ordered W before DR, so the read returns the new data.
- A request with RDEN low has no effect. Address bits above ADDR_W+1 and bits [1:0] are ignored.
- Reset asserted mid-SERIAL: pending requests are dropped and no responses are produced. After release, the core's re-presented requests are treated as new, in IDLE.
- RTL assertion (bench checks it): no capture ever overwrites an unconsumed response of the same port.

Test Plan:
- Reset: hold RST=0 with all requests high → MEM_WAIT=0, RAM_EN=0, all RVALID=0, ROADDR=RDATA=0.
- Single fetch: INST_RIADDR=0x100, RAM[0x40]=0xDEADBEEF → cycle 0: RAM_EN=1, RAM_ADDR=0x40, MEM_WAIT=0. Cycle 2: INST_RVALID=1, INST_ROADDR=0x100, INST_RDATA=0xDEADBEEF. Cycle 3: INST_RVALID=0.
- Streaming: INST_RDEN held high, addresses 0x0, 0x4, 0x8 on consecutive cycles → INST_RVALID high in cycles 2–4 with ROADDR 0x0, 0x4, 0x8 in order. MEM_WAIT stays 0.
- Three-way collision: WREN 0x200←0x12345678, RDEN 0x200, INST 0x0, all held → MEM_WAIT=1,1,0.
  - RAM accesses: W@0x80, R@0x80, R@0x0.
  - DATA_RDATA=0x12345678 with DATA_ROADDR=0x200.
  - INST_RVALID appears exactly once.
- Hold under stall: create a collision the cycle after an inst read → the INST response that appears while MEM_WAIT=1 stays stable across those cycles and clears one cycle after MEM_WAIT=0.
- Reset mid-SERIAL: assert RST=0 in cycle 1 of a 3-way collision → MEM_WAIT and RAM_EN drop immediately. After release, state is IDLE and no stale RVALID appears.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if
//
// Bundles the core-facing memory request/response signals and the RAM-side
// access signals of the memory responder into one interface.
//
// Modports:
//   slave  - the responder: takes core requests and RAM read data, drives
//            responses, MEM_WAIT and the RAM access signals.
//   master - the core/RAM environment: the mirror image of slave.
//
// Signals:
//   INST_RDEN/INST_RIADDR         instruction read request and byte address
//   INST_RVALID/ROADDR/RDATA      instruction response
//   DATA_RDEN/DATA_RIADDR         data read request and byte address
//   DATA_RVALID/ROADDR/RDATA      data response
//   DATA_WREN/WADDR/WDATA         full-word data write request
//   MEM_WAIT                      stall; core holds all requests while high
//   RAM_EN/WE/ADDR/WDATA          single-port RAM access (word address)
//   RAM_RDATA                     RAM read data, valid the cycle after a read
interface mem_responder_if #(
    parameter int ADDR_W = 14
);
    logic              INST_RDEN;
    logic [31:0]       INST_RIADDR;
    logic [31:0]       INST_ROADDR;
    logic              INST_RVALID;
    logic [31:0]       INST_RDATA;

    logic              DATA_RDEN;
    logic [31:0]       DATA_RIADDR;
    logic [31:0]       DATA_ROADDR;
    logic              DATA_RVALID;
    logic [31:0]       DATA_RDATA;

    logic              DATA_WREN;
    logic [31:0]       DATA_WADDR;
    logic [31:0]       DATA_WDATA;

    logic              MEM_WAIT;

    logic              RAM_EN;
    logic              RAM_WE;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [31:0]       RAM_WDATA;
    logic [31:0]       RAM_RDATA;

    modport slave (
        input  INST_RDEN,
        input  INST_RIADDR,
        output INST_ROADDR,
        output INST_RVALID,
        output INST_RDATA,
        input  DATA_RDEN,
        input  DATA_RIADDR,
        output DATA_ROADDR,
        output DATA_RVALID,
        output DATA_RDATA,
        input  DATA_WREN,
        input  DATA_WADDR,
        input  DATA_WDATA,
        output MEM_WAIT,
        output RAM_EN,
        output RAM_WE,
        output RAM_ADDR,
        output RAM_WDATA,
        input  RAM_RDATA
    );

    modport master (
        output INST_RDEN,
        output INST_RIADDR,
        input  INST_ROADDR,
        input  INST_RVALID,
        input  INST_RDATA,
        output DATA_RDEN,
        output DATA_RIADDR,
        input  DATA_ROADDR,
        input  DATA_RVALID,
        input  DATA_RDATA,
        output DATA_WREN,
        output DATA_WADDR,
        output DATA_WDATA,
        input  MEM_WAIT,
        input  RAM_EN,
        input  RAM_WE,
        input  RAM_ADDR,
        input  RAM_WDATA,
        output RAM_RDATA
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//
// Memory-side responder for the core's instruction and data ports, sitting
// in front of a single-port synchronous RAM. Serves instruction reads, data
// reads and full-word data writes, one RAM access per cycle. When several
// requests arrive together they are issued in the order write, data read,
// instruction read, and MEM_WAIT stalls the core until the last one issues.
//
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RST  - asynchronous active-low reset
//   bus  - mem_responder_if.slave: core requests/responses, MEM_WAIT and the
//          RAM access signals (see the interface file)
//
// Timing: a read issued in cycle N is captured from RAM_RDATA at the end of
// cycle N+1 and presented (RVALID/ROADDR/RDATA) in cycle N+2. A response is
// held while MEM_WAIT is high and dropped after the first cycle it is seen
// with MEM_WAIT low, unless a new response for that port lands at that edge.
module mem_responder #(
    parameter int ADDR_W = 14
) (
    input logic            CLK,
    input logic            RST,
    mem_responder_if.slave bus
);

    typedef enum logic {
        IDLE,
        SERIAL
    } state_t;

    // Request vector bit positions; a higher bit means higher priority.
    localparam int W_BIT  = 2;
    localparam int DR_BIT = 1;
    localparam int IR_BIT = 0;

    state_t            state;
    state_t            state_next;
    logic [2:0]        pending;
    logic [2:0]        pending_next;

    logic [2:0]        req_now;
    logic [2:0]        active;
    logic [2:0]        sel;
    logic [2:0]        remaining;
    logic              mem_wait;
    logic [ADDR_W-1:0] issue_word;

    logic              tag_valid;
    logic              tag_port;
    logic [31:0]       tag_addr;

    logic              capture_inst;
    logic              capture_data;

    logic              inst_rvalid;
    logic [31:0]       inst_roaddr;
    logic [31:0]       inst_rdata;
    logic              data_rvalid;
    logic [31:0]       data_roaddr;
    logic [31:0]       data_rdata;

    assign req_now = {bus.DATA_WREN, bus.DATA_RDEN, bus.INST_RDEN};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    // In IDLE the live requests compete; in SERIAL only the requests left
    // over from the colliding group do. The core holds its inputs during
    // SERIAL, so the addresses and write data are still read from the bus.
    // Whatever is not issued this cycle becomes the pending mask, which also
    // decides whether the core must keep stalling.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        active       = '0;
        sel          = '0;
        remaining    = '0;
        mem_wait     = 1'b0;

        if (state == SERIAL) begin
            active = pending;
        end else begin
            active = req_now;
        end

        if (active[W_BIT]) begin
            sel = 3'b100;
        end else if (active[DR_BIT]) begin
            sel = 3'b010;
        end else if (active[IR_BIT]) begin
            sel = 3'b001;
        end

        remaining    = active & ~sel;
        mem_wait     = |remaining;
        pending_next = remaining;
        state_next   = mem_wait ? SERIAL : IDLE;
    end

    // Word address of the issued request; the shift drops the byte offset
    // and the cast drops address bits beyond the RAM.
    always_comb begin
        issue_word = '0;
        if (sel[W_BIT]) begin
            issue_word = ADDR_W'(bus.DATA_WADDR >> 2);
        end else if (sel[DR_BIT]) begin
            issue_word = ADDR_W'(bus.DATA_RIADDR >> 2);
        end else if (sel[IR_BIT]) begin
            issue_word = ADDR_W'(bus.INST_RIADDR >> 2);
        end
    end

    // Reset must silence the RAM and the stall immediately, even though the
    // request inputs may still be asserted.
    assign bus.RAM_EN    = RST & (|sel);
    assign bus.RAM_WE    = RST & sel[W_BIT];
    assign bus.RAM_ADDR  = issue_word;
    assign bus.RAM_WDATA = sel[W_BIT] ? bus.DATA_WDATA : 32'h0;
    assign bus.MEM_WAIT  = RST & mem_wait;

    // The tag remembers which port a read was issued for and its full byte
    // address, so the RAM data arriving next cycle can be routed back.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_valid <= 1'b0;
            tag_port  <= 1'b0;
            tag_addr  <= 32'h0;
        end else begin
            tag_valid <= sel[DR_BIT] | sel[IR_BIT];
            tag_port  <= sel[DR_BIT];
            tag_addr  <= sel[DR_BIT] ? bus.DATA_RIADDR : bus.INST_RIADDR;
        end
    end

    assign capture_inst = tag_valid & ~tag_port;
    assign capture_data = tag_valid & tag_port;

    // A new capture takes precedence over consumption at the same edge, so
    // back-to-back reads stream one response per cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inst_rvalid <= 1'b0;
            inst_roaddr <= 32'h0;
            inst_rdata  <= 32'h0;
        end else if (capture_inst) begin
            inst_rvalid <= 1'b1;
            inst_roaddr <= tag_addr;
            inst_rdata  <= bus.RAM_RDATA;
        end else if (inst_rvalid && !mem_wait) begin
            inst_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_rvalid <= 1'b0;
            data_roaddr <= 32'h0;
            data_rdata  <= 32'h0;
        end else if (capture_data) begin
            data_rvalid <= 1'b1;
            data_roaddr <= tag_addr;
            data_rdata  <= bus.RAM_RDATA;
        end else if (data_rvalid && !mem_wait) begin
            data_rvalid <= 1'b0;
        end
    end

    assign bus.INST_RVALID = inst_rvalid;
    assign bus.INST_ROADDR = inst_roaddr;
    assign bus.INST_RDATA  = inst_rdata;
    assign bus.DATA_RVALID = data_rvalid;
    assign bus.DATA_ROADDR = data_roaddr;
    assign bus.DATA_RDATA  = data_rdata;

    // A capture landing on a response the core has not yet consumed would
    // silently lose that response.
    assert property (@(posedge CLK) disable iff (!RST)
        (capture_inst && inst_rvalid) |-> !mem_wait)
        else $error("mem_responder: instruction response overwritten before consumption");

    assert property (@(posedge CLK) disable iff (!RST)
        (capture_data && data_rvalid) |-> !mem_wait)
        else $error("mem_responder: data response overwritten before consumption");

    // Leaving SERIAL always empties the pending mask.
    assert property (@(posedge CLK) disable iff (!RST)
        (state == IDLE) |-> (pending == 3'b000))
        else $error("mem_responder: pending requests left while idle");

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//
// Drives mem_responder through directed scenarios (reset, single fetch,
// streaming, three-way collision, hold under stall, reset mid-collision)
// followed by randomized request groups. A behavioural RAM answers the RAM
// port. Expected responses come from a reference memory that applies each
// request group in write, data-read, instruction-read order; a monitor pops
// them whenever a response is consumed.
module tb_mem_responder;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic CLK;
    logic RST;

    mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    mem_responder #(.ADDR_W(ADDR_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [63:0] inst_q [$];
    logic [63:0] data_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural single-port synchronous RAM.
    always @(posedge CLK) begin
        if (bus.RAM_EN) begin
            if (bus.RAM_WE) begin
                ram[bus.RAM_ADDR] <= bus.RAM_WDATA;
            end else begin
                bus.RAM_RDATA <= ram[bus.RAM_ADDR];
            end
        end
    end

    function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] a);
        return ADDR_W'(a >> 2);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one request group; with expect_resp set, the reference model
    // applies the group in priority order and queues the read results.
    task automatic apply_stimulus(input logic i_en, input logic [31:0] i_addr,
                                  input logic dr_en, input logic [31:0] dr_addr,
                                  input logic w_en, input logic [31:0] w_addr,
                                  input logic [31:0] w_data, input bit expect_resp);
        bus.INST_RDEN   = i_en;
        bus.INST_RIADDR = i_addr;
        bus.DATA_RDEN   = dr_en;
        bus.DATA_RIADDR = dr_addr;
        bus.DATA_WREN   = w_en;
        bus.DATA_WADDR  = w_addr;
        bus.DATA_WDATA  = w_data;
        if (expect_resp) begin
            if (w_en) ref_mem[word_of(w_addr)] = w_data;
            if (dr_en) data_q.push_back({dr_addr, ref_mem[word_of(dr_addr)]});
            if (i_en) inst_q.push_back({i_addr, ref_mem[word_of(i_addr)]});
        end
    endtask

    task automatic clear_inputs();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge CLK);
            clear_inputs();
        end
    endtask

    // Keeps the current group presented until the stall drops.
    task automatic hold_group();
        int guard;
        guard = 0;
        #1;
        while (bus.MEM_WAIT) begin
            @(negedge CLK);
            guard++;
            if (guard > 4) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL mem_wait_timeout: got MEM_WAIT stuck for %0d cycles, expected at most 2", guard);
                break;
            end
            #1;
        end
    endtask

    // Response monitor: a visible response must match the oldest expected
    // one; it is retired in the cycle it is consumed (MEM_WAIT low).
    always begin
        @(negedge CLK);
        #2;
        if (RST) begin
            if (bus.INST_RVALID) begin
                if (inst_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL inst_unexpected: got response addr %h, expected none", bus.INST_ROADDR);
                end else begin
                    check_output("inst_resp", {bus.INST_ROADDR, bus.INST_RDATA}, inst_q[0]);
                    if (!bus.MEM_WAIT) void'(inst_q.pop_front());
                end
            end
            if (bus.DATA_RVALID) begin
                if (data_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL data_unexpected: got response addr %h, expected none", bus.DATA_ROADDR);
                end else begin
                    check_output("data_resp", {bus.DATA_ROADDR, bus.DATA_RDATA}, data_q[0]);
                    if (!bus.MEM_WAIT) void'(data_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] mask;
        bit         prev_idle;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i] = ram[i];
        end
        ram[14'h40]     = 32'hDEADBEEF;
        ref_mem[14'h40] = 32'hDEADBEEF;

        // Reset with every request asserted.
        RST = 1'b0;
        apply_stimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 32'hFFFF0000, 1'b0);
        repeat (3) @(negedge CLK);
        #1;
        check_output("rst_mem_wait", 64'(bus.MEM_WAIT), 64'd0);
        check_output("rst_ram_en", 64'(bus.RAM_EN), 64'd0);
        check_output("rst_ram_we", 64'(bus.RAM_WE), 64'd0);
        check_output("rst_inst_rvalid", 64'(bus.INST_RVALID), 64'd0);
        check_output("rst_data_rvalid", 64'(bus.DATA_RVALID), 64'd0);
        check_output("rst_inst_roaddr", 64'(bus.INST_ROADDR), 64'd0);
        check_output("rst_inst_rdata", 64'(bus.INST_RDATA), 64'd0);
        check_output("rst_data_roaddr", 64'(bus.DATA_ROADDR), 64'd0);
        check_output("rst_data_rdata", 64'(bus.DATA_RDATA), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        clear_inputs();
        idle_cycles(2);

        // Single fetch.
        @(negedge CLK);
        apply_stimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        check_output("fetch_ram_en", 64'(bus.RAM_EN), 64'd1);
        check_output("fetch_ram_addr", 64'(bus.RAM_ADDR), 64'h40);
        check_output("fetch_mem_wait", 64'(bus.MEM_WAIT), 64'd0);
        idle_cycles(1);
        @(negedge CLK);
        #1;
        check_output("fetch_rvalid", 64'(bus.INST_RVALID), 64'd1);
        check_output("fetch_roaddr", 64'(bus.INST_ROADDR), 64'h100);
        check_output("fetch_rdata", 64'(bus.INST_RDATA), 64'hDEADBEEF);
        @(negedge CLK);
        #1;
        check_output("fetch_rvalid_clear", 64'(bus.INST_RVALID), 64'd0);
        idle_cycles(3);

        // Streaming instruction reads.
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (c < 3) apply_stimulus(1'b1, 32'(4 * c), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
            else clear_inputs();
            #1;
            if (c < 3) check_output("stream_mem_wait", 64'(bus.MEM_WAIT), 64'd0);
            if (c >= 2 && c <= 4) begin
                check_output("stream_rvalid", 64'(bus.INST_RVALID), 64'd1);
                check_output("stream_roaddr", 64'(bus.INST_ROADDR), 64'(4 * (c - 2)));
            end
            if (c == 5) check_output("stream_rvalid_clear", 64'(bus.INST_RVALID), 64'd0);
        end
        idle_cycles(3);

        // Three-way collision with read-after-write to the same word.
        @(negedge CLK);
        apply_stimulus(1'b1, 32'h0, 1'b1, 32'h200, 1'b1, 32'h200, 32'h12345678, 1'b1);
        #1;
        check_output("coll_wait0", 64'(bus.MEM_WAIT), 64'd1);
        check_output("coll_we0", 64'(bus.RAM_WE), 64'd1);
        check_output("coll_addr0", 64'(bus.RAM_ADDR), 64'h80);
        check_output("coll_wdata0", 64'(bus.RAM_WDATA), 64'h12345678);
        @(negedge CLK);
        #1;
        check_output("coll_wait1", 64'(bus.MEM_WAIT), 64'd1);
        check_output("coll_en1", 64'(bus.RAM_EN), 64'd1);
        check_output("coll_we1", 64'(bus.RAM_WE), 64'd0);
        check_output("coll_addr1", 64'(bus.RAM_ADDR), 64'h80);
        @(negedge CLK);
        #1;
        check_output("coll_wait2", 64'(bus.MEM_WAIT), 64'd0);
        check_output("coll_en2", 64'(bus.RAM_EN), 64'd1);
        check_output("coll_we2", 64'(bus.RAM_WE), 64'd0);
        check_output("coll_addr2", 64'(bus.RAM_ADDR), 64'h0);
        @(negedge CLK);
        clear_inputs();
        #1;
        check_output("coll_data_rvalid", 64'(bus.DATA_RVALID), 64'd1);
        check_output("coll_data_roaddr", 64'(bus.DATA_ROADDR), 64'h200);
        check_output("coll_data_rdata", 64'(bus.DATA_RDATA), 64'h12345678);
        @(negedge CLK);
        #1;
        check_output("coll_inst_rvalid", 64'(bus.INST_RVALID), 64'd1);
        idle_cycles(3);

        // Instruction response held while a following collision stalls.
        @(negedge CLK);
        apply_stimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge CLK);
        apply_stimulus(1'b1, 32'h500, 1'b1, 32'h40C, 1'b1, 32'h40C, 32'hA5A5C3C3, 1'b1);
        #1;
        check_output("hold_wait1", 64'(bus.MEM_WAIT), 64'd1);
        @(negedge CLK);
        #1;
        check_output("hold_wait2", 64'(bus.MEM_WAIT), 64'd1);
        check_output("hold_rvalid2", 64'(bus.INST_RVALID), 64'd1);
        check_output("hold_roaddr2", 64'(bus.INST_ROADDR), 64'h300);
        @(negedge CLK);
        #1;
        check_output("hold_wait3", 64'(bus.MEM_WAIT), 64'd0);
        check_output("hold_rvalid3", 64'(bus.INST_RVALID), 64'd1);
        check_output("hold_roaddr3", 64'(bus.INST_ROADDR), 64'h300);
        @(negedge CLK);
        clear_inputs();
        #1;
        check_output("hold_rvalid4", 64'(bus.INST_RVALID), 64'd0);
        @(negedge CLK);
        #1;
        check_output("hold_rvalid5", 64'(bus.INST_RVALID), 64'd1);
        check_output("hold_roaddr5", 64'(bus.INST_ROADDR), 64'h500);
        idle_cycles(3);

        // Reset during the second cycle of a three-way collision; only the
        // write (already issued) reaches the RAM.
        @(negedge CLK);
        apply_stimulus(1'b1, 32'h24, 1'b1, 32'h20, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
        ref_mem[word_of(32'h20)] = 32'hCAFEF00D;
        #1;
        check_output("rstmid_wait0", 64'(bus.MEM_WAIT), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_output("rstmid_wait", 64'(bus.MEM_WAIT), 64'd0);
        check_output("rstmid_ram_en", 64'(bus.RAM_EN), 64'd0);
        repeat (2) begin
            @(negedge CLK);
            #1;
            check_output("rstmid_inst_rvalid", 64'(bus.INST_RVALID), 64'd0);
            check_output("rstmid_data_rvalid", 64'(bus.DATA_RVALID), 64'd0);
        end
        @(negedge CLK);
        RST = 1'b1;
        apply_stimulus(1'b1, 32'h24, 1'b1, 32'h20, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1);
        #1;
        check_output("rstrel_wait", 64'(bus.MEM_WAIT), 64'd1);
        check_output("rstrel_we", 64'(bus.RAM_WE), 64'd1);
        check_output("rstrel_inst_rvalid", 64'(bus.INST_RVALID), 64'd0);
        check_output("rstrel_data_rvalid", 64'(bus.DATA_RVALID), 64'd0);
        hold_group();
        idle_cycles(3);

        // Randomized groups; a colliding group is only presented after a
        // request-free cycle and is followed by one.
        prev_idle = 1'b1;
        for (int g = 0; g < 400; g++) begin
            mask = 3'($urandom_range(0, 7));
            if (!prev_idle && $countones(mask) > 1) mask = mask & (~mask + 3'd1);
            @(negedge CLK);
            apply_stimulus(mask[0], rand_addr(), mask[1], rand_addr(), mask[2], rand_addr(),
                           $urandom, 1'b1);
            hold_group();
            if ($countones(mask) > 1) begin
                idle_cycles(1);
                prev_idle = 1'b1;
            end else begin
                prev_idle = (mask == 3'b000);
            end
        end

        idle_cycles(6);
        check_output("inst_q_drained", 64'(inst_q.size()), 64'd0);
        check_output("data_q_drained", 64'(data_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
